// File: rtl/fxp_neuron_sequencer_if.sv
// Bundle of the layer-controller, buffer-read and result-handshake signals of
// the neuron sequencer. The slave side is the sequencer; master is controller+buffers.
interface fxp_neuron_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 9
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] x_base;
  logic [15:0]       bias;
  logic              relu_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] x_addr;
  logic [15:0]       w_data;
  logic [15:0]       x_data;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;

  modport master (
    output start, len, w_base, x_base, bias, relu_en, w_data, x_data, out_ready,
    input  mem_rd_en, w_addr, x_addr, busy, out_valid, out_data
  );

  modport slave (
    input  start, len, w_base, x_base, bias, relu_en, w_data, x_data, out_ready,
    output mem_rd_en, w_addr, x_addr, busy, out_valid, out_data
  );
endinterface

// File: rtl/fxp_neuron_sequencer.sv
// Single-neuron Q8.8 dot product on one shared MAC: read -> product -> accumulate,
// then bias, floor, saturate, optional ReLU, and a valid/ready result handshake.
module fxp_neuron_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 9,
  parameter int ACC_W  = 42
) (
  input  logic                     clk,
  input  logic                     rst,
  fxp_neuron_sequencer_if.slave    bus
);

  localparam int STAGES = 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, FINAL, OUT} state_t;

  state_t                   state, state_nxt;
  logic [LEN_W-1:0]         len_q, idx;
  logic [ADDR_W-1:0]        w_ptr, x_ptr;
  logic signed [15:0]       bias_q;
  logic                     relu_q;
  logic [STAGES:0]          vld_pipe;
  logic signed [31:0]       w_ext, x_ext, prod_q;
  logic signed [ACC_W-1:0]  acc, t_sum, r_shift;
  logic [15:0]              r_fin, out_q;
  logic                     accept, last_rd, rd_en;

  // vld_pipe[0]: read data present on w_data/x_data; vld_pipe[1]: prod_q valid
  assign w_ext   = {{16{bus.w_data[15]}}, bus.w_data};
  assign x_ext   = {{16{bus.x_data[15]}}, bus.x_data};
  assign last_rd = (idx == len_q - LEN_W'(1));
  assign rd_en   = (state == FETCH);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:  if (bus.start) begin
               accept    = 1'b1;
               state_nxt = (bus.len != '0) ? FETCH : FINAL;
             end
      FETCH: if (last_rd) state_nxt = DRAIN;
      // leave once the accumulate stage takes the final product this edge
      DRAIN: if (vld_pipe[1] && !vld_pipe[0]) state_nxt = FINAL;
      FINAL: state_nxt = OUT;
      OUT:   if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      idx      <= '0;
      w_ptr    <= '0;
      x_ptr    <= '0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
      vld_pipe <= '0;
      prod_q   <= '0;
      acc      <= '0;
      out_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_en};
      if (vld_pipe[0]) prod_q <= w_ext * x_ext;
      if (accept) begin
        len_q  <= bus.len;
        bias_q <= bus.bias;
        relu_q <= bus.relu_en;
        w_ptr  <= bus.w_base;
        x_ptr  <= bus.x_base;
        idx    <= '0;
        acc    <= '0;
      end else begin
        if (rd_en) begin
          idx   <= idx + LEN_W'(1);
          w_ptr <= w_ptr + ADDR_W'(1);
          x_ptr <= x_ptr + ADDR_W'(1);
        end
        if (vld_pipe[1]) acc <= acc + {{(ACC_W-32){prod_q[31]}}, prod_q};
      end
      if (state == FINAL) out_q <= r_fin;
    end
  end

  // Bias aligned to Q16.16, arithmetic shift back to Q8.8 floors toward -inf
  always_comb begin
    t_sum   = acc + {{(ACC_W-24){bias_q[15]}}, bias_q, 8'h00};
    r_shift = t_sum >>> 8;
    if (r_shift > SAT_MAX)      r_fin = 16'h7FFF;
    else if (r_shift < SAT_MIN) r_fin = 16'h8000;
    else                        r_fin = r_shift[15:0];
    if (relu_q && r_fin[15]) r_fin = 16'h0000;
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.w_addr    = w_ptr;
  assign bus.x_addr    = x_ptr;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = out_q;

endmodule
